// File: rtl/mmio_uart_bridge_pkg.sv
// Shared constants and helpers for the memory-mapped UART/clock I/O bridge.
package mmio_uart_bridge_pkg;

    localparam logic [31:0] IO_ADDR_UART = 32'h0003_0000;
    localparam logic [31:0] IO_ADDR_CLK  = 32'h0003_0004;
    localparam logic [1:0]  IO_SPACE     = 2'b11;

    localparam logic [2:0]  OFF_UART     = IO_ADDR_UART[2:0];
    localparam logic [2:0]  OFF_CLK      = IO_ADDR_CLK[2:0];

    // Source of the byte returned one cycle after an I/O read.
    typedef enum logic [1:0] {
        RSEL_ZERO,
        RSEL_RX,
        RSEL_CLK,
        RSEL_SNAP
    } rsel_e;

    function automatic logic [7:0] snap_byte(input logic [31:0] snap, input logic [1:0] idx);
        return snap[{idx, 3'b000} +: 8];
    endfunction

endpackage

// File: rtl/mmio_uart_bridge_sync_fifo.sv
// Synchronous FIFO with wrap-flag pointers; push and pop in one cycle are both taken even when full.
module sync_fifo #(
    parameter int unsigned WID = 8,
    parameter int unsigned AW  = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           push,
    input  logic [WID-1:0] push_data,
    input  logic           pop,
    output logic [WID-1:0] pop_data,
    output logic           full,
    output logic           empty,
    output logic [AW:0]    count,
    output logic [AW:0]    count_nxt
);

    logic [WID-1:0] mem [2**AW];
    logic [AW:0]    wr_ptr;
    logic [AW:0]    rd_ptr;
    logic           do_push;
    logic           do_pop;

    assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty     = (wr_ptr == rd_ptr);
    assign count     = wr_ptr - rd_ptr;
    assign do_pop    = pop && !empty;
    // A pop frees the head slot in the same cycle, so a push into a full FIFO is still safe.
    assign do_push   = push && (!full || do_pop);
    assign count_nxt = count + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
    assign pop_data  = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= push_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/mmio_uart_bridge.sv
// I/O-space slave on the cpu byte bus: UART TX/RX ports, cycle counter snapshot and program stop.
module mmio_uart_bridge
    import mmio_uart_bridge_pkg::*;
#(
    parameter int unsigned TX_AW       = 4,
    parameter int unsigned RX_AW       = 4,
    parameter int unsigned FULL_MARGIN = 2
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic [31:0] mem_a,
    input  logic [7:0]  mem_dout,
    input  logic        mem_wr,
    output logic [7:0]  io_din,
    output logic        io_buffer_full,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        prog_finish,
    output logic        tx_overflow
);

    localparam int unsigned      FULL_LEVEL_I = (32'd1 << TX_AW) - FULL_MARGIN;
    localparam logic [TX_AW:0]   FULL_LEVEL   = FULL_LEVEL_I[TX_AW:0];

    logic        io_hit;
    logic        io_rd;
    logic        io_wr;
    logic [2:0]  io_off;
    rsel_e       rsel;
    logic [7:0]  rd_data;

    logic [31:0] cycle_cnt;
    logic [31:0] snap;
    logic        stop_pend;

    logic        tx_push_req;
    logic [7:0]  tx_push_data;
    logic        tx_pop;
    logic        tx_full;
    logic        tx_empty;
    logic [TX_AW:0] tx_count_nxt;
    logic [TX_AW:0] unused_tx_count;

    logic        rx_pop;
    logic [7:0]  rx_head;
    logic        rx_empty;
    logic        unused_rx_full;
    logic [RX_AW:0] unused_rx_count;
    logic [RX_AW:0] unused_rx_count_nxt;
    logic        unused_addr;

    assign io_hit      = rdy_in && (mem_a[17:16] == IO_SPACE);
    assign io_rd       = io_hit && !mem_wr;
    assign io_wr       = io_hit && mem_wr;
    assign io_off      = mem_a[2:0];
    assign unused_addr = ^{mem_a[31:18], mem_a[15:3]};

    // A stop write enqueues a literal zero; once stop is pending all further TX writes are dropped.
    assign tx_push_req  = io_wr && !stop_pend &&
                          (((io_off == OFF_UART) && (mem_dout != 8'h00)) || (io_off == OFF_CLK));
    assign tx_push_data = (io_off == OFF_CLK) ? 8'h00 : mem_dout;
    assign tx_valid     = !tx_empty;
    assign tx_pop       = tx_valid && tx_ready;

    assign rx_pop = io_rd && (io_off == OFF_UART) && !rx_empty;

    sync_fifo #(
        .WID (8),
        .AW  (TX_AW)
    ) u_tx_fifo (
        .clk       (clk_in),
        .rst       (rst_in),
        .push      (tx_push_req),
        .push_data (tx_push_data),
        .pop       (tx_pop),
        .pop_data  (tx_data),
        .full      (tx_full),
        .empty     (tx_empty),
        .count     (unused_tx_count),
        .count_nxt (tx_count_nxt)
    );

    sync_fifo #(
        .WID (8),
        .AW  (RX_AW)
    ) u_rx_fifo (
        .clk       (clk_in),
        .rst       (rst_in),
        .push      (rx_valid),
        .push_data (rx_data),
        .pop       (rx_pop),
        .pop_data  (rx_head),
        .full      (unused_rx_full),
        .empty     (rx_empty),
        .count     (unused_rx_count),
        .count_nxt (unused_rx_count_nxt)
    );

    always_comb begin
        rsel = RSEL_ZERO;
        if (io_rd) begin
            case (io_off)
                OFF_UART:                 rsel = RSEL_RX;
                OFF_CLK:                  rsel = RSEL_CLK;
                3'd5, 3'd6, 3'd7:         rsel = RSEL_SNAP;
                default:                  rsel = RSEL_ZERO;
            endcase
        end
    end

    always_comb begin
        rd_data = 8'h00;
        case (rsel)
            RSEL_RX:   rd_data = rx_empty ? 8'h00 : rx_head;
            RSEL_CLK:  rd_data = cycle_cnt[7:0];
            RSEL_SNAP: rd_data = snap_byte(snap, io_off[1:0]);
            default:   rd_data = 8'h00;
        endcase
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            cycle_cnt      <= '0;
            snap           <= '0;
            io_din         <= '0;
            io_buffer_full <= 1'b0;
            stop_pend      <= 1'b0;
            prog_finish    <= 1'b0;
            tx_overflow    <= 1'b0;
        end else begin
            cycle_cnt      <= cycle_cnt + 32'd1;
            io_buffer_full <= (tx_count_nxt >= FULL_LEVEL);
            if (io_wr && (io_off == OFF_CLK)) begin
                stop_pend <= 1'b1;
            end
            if (tx_push_req && tx_full && !tx_pop) begin
                tx_overflow <= 1'b1;
            end
            if (stop_pend && tx_empty && !tx_pop) begin
                prog_finish <= 1'b1;
            end
            if (rsel == RSEL_CLK) begin
                snap <= cycle_cnt;
            end
            // io_din holds its value across non-I/O cycles, like a RAM output register.
            if (io_rd) begin
                io_din <= rd_data;
            end
        end
    end

endmodule
